// File: rtl/lfm_sweep_ctrl.sv
// lfm_sweep_ctrl
//   Stepped linear-FM sweep controller. Issues one phase increment per step to a
//   DDS over an AXI-Stream style handshake, then dwells for STEP_LEN DDS output
//   samples before moving to the next step. After NUM_STEPS steps the sweep ends.
//
//   Build option: define LFM_CONTINUOUS_EN to restart the sweep automatically
//   from START_INC after every sweep (until stop or reset). Without it the block
//   returns to IDLE after each sweep and waits for a new start.
//
//   Ports
//     clk           in   clock, rising edge
//     reset         in   asynchronous active-high reset
//     start         in   request sweep start (honoured in IDLE only)
//     stop          in   request sweep abort (wins over start)
//     sample_valid  in   DDS output-sample strobe, paces the dwell
//     phase_tvalid  out  valid toward DDS phase input
//     phase_tready  in   ready from DDS phase input
//     phase_tdata   out  32-bit phase increment
//     sweep_active  out  high while in LOAD, DWELL or DONE
//     step_last     out  one-cycle pulse after the final sample of each step
//     sweep_done    out  one-cycle pulse at sweep end (the DONE cycle)
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | phase increment offered to DDS, waiting for handshake
//   DWELL | counting DDS samples for the current step
//   DONE  | single cycle marking the end of a sweep

module lfm_sweep_ctrl #(
    parameter int unsigned STEP_LEN  = 100,
    parameter logic [31:0] START_INC = 32'h028F5C29,
    parameter logic [31:0] STEP_INC  = 32'h028F5C29,
    parameter int unsigned NUM_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        sample_valid,
    output logic        phase_tvalid,
    input  logic        phase_tready,
    output logic [31:0] phase_tdata,
    output logic        sweep_active,
    output logic        step_last,
    output logic        sweep_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_SAMPLE = 16'(STEP_LEN - 1);
    localparam logic [15:0] LAST_STEP   = 16'(NUM_STEPS - 1);

    state_t      state_q, state_d;
    logic        phase_tvalid_q, phase_tvalid_d;
    logic [31:0] phase_tdata_q, phase_tdata_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] step_idx_q, step_idx_d;
    logic        step_last_q, step_last_d;
    logic        sweep_done_q, sweep_done_d;
    logic        sweep_active_q, sweep_active_d;
    logic        stop_lat_q, stop_lat_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_tvalid_q <= 1'b0;
            phase_tdata_q  <= START_INC;
            sample_cnt_q   <= 16'd0;
            step_idx_q     <= 16'd0;
            step_last_q    <= 1'b0;
            sweep_done_q   <= 1'b0;
            sweep_active_q <= 1'b0;
            stop_lat_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_tvalid_q <= phase_tvalid_d;
            phase_tdata_q  <= phase_tdata_d;
            sample_cnt_q   <= sample_cnt_d;
            step_idx_q     <= step_idx_d;
            step_last_q    <= step_last_d;
            sweep_done_q   <= sweep_done_d;
            sweep_active_q <= sweep_active_d;
            stop_lat_q     <= stop_lat_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_tvalid_d = phase_tvalid_q;
        phase_tdata_d  = phase_tdata_q;
        sample_cnt_d   = sample_cnt_q;
        step_idx_d     = step_idx_q;
        step_last_d    = 1'b0;
        sweep_done_d   = 1'b0;
        stop_lat_d     = stop_lat_q;

        case (state_q)
            IDLE: begin
                stop_lat_d = 1'b0;
                if (start && !stop) begin
                    state_d        = LOAD;
                    phase_tvalid_d = 1'b1;
                    phase_tdata_d  = START_INC;
                    step_idx_d     = 16'd0;
                end
            end
            LOAD: begin
                // A stop seen here is held until the offered increment is
                // accepted, so valid never drops without a handshake.
                if (phase_tvalid_q && phase_tready) begin
                    phase_tvalid_d = 1'b0;
                    sample_cnt_d   = 16'd0;
                    stop_lat_d     = 1'b0;
                    state_d        = (stop_lat_q || stop) ? IDLE : DWELL;
                end else if (stop) begin
                    stop_lat_d = 1'b1;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sample_valid) begin
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        step_last_d = 1'b1;
                        if (step_idx_q < LAST_STEP) begin
                            phase_tdata_d  = phase_tdata_q + STEP_INC;
                            step_idx_d     = step_idx_q + 16'd1;
                            phase_tvalid_d = 1'b1;
                            state_d        = LOAD;
                        end else begin
                            sweep_done_d = 1'b1;
                            state_d      = DONE;
                        end
                    end
                end
            end
            DONE: begin
`ifdef LFM_CONTINUOUS_EN
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    state_d        = LOAD;
                    phase_tvalid_d = 1'b1;
                    phase_tdata_d  = START_INC;
                    step_idx_d     = 16'd0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d        = IDLE;
                phase_tvalid_d = 1'b0;
            end
        endcase

        sweep_active_d = (state_d != IDLE);
    end

    assign phase_tvalid = phase_tvalid_q;
    assign phase_tdata  = phase_tdata_q;
    assign sweep_active = sweep_active_q;
    assign step_last    = step_last_q;
    assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_lfm_sweep_ctrl.sv
// Testbench for lfm_sweep_ctrl. Expected phase increments are queued when a
// sweep is started and popped on every observed phase handshake.
module tb_lfm_sweep_ctrl;

    localparam int unsigned STEP_LEN  = 100;
    localparam int unsigned NUM_STEPS = 16;
    localparam logic [31:0] START     = 32'h028F5C29;
    localparam logic [31:0] STEP      = 32'h028F5C29;
`ifdef LFM_CONTINUOUS_EN
    localparam int N_SWEEP = 2;
`else
    localparam int N_SWEEP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_w = 1'b0;
    logic stop = 1'b0;
    logic sample_valid = 1'b0;
    logic phase_tready = 1'b0;

    logic        phase_tvalid, sweep_active, step_last, sweep_done;
    logic [31:0] phase_tdata;
    logic        w_phase_tvalid, w_sweep_active, w_step_last, w_sweep_done;
    logic [31:0] w_phase_tdata;

    always #5 clk = ~clk;

    lfm_sweep_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .phase_tvalid (phase_tvalid),
        .phase_tready (phase_tready),
        .phase_tdata  (phase_tdata),
        .sweep_active (sweep_active),
        .step_last    (step_last),
        .sweep_done   (sweep_done)
    );

    lfm_sweep_ctrl #(
        .STEP_LEN  (3),
        .START_INC (32'hFFFFFFF0),
        .STEP_INC  (32'h00000020),
        .NUM_STEPS (2)
    ) dut_wrap (
        .clk          (clk),
        .reset        (reset),
        .start        (start_w),
        .stop         (stop),
        .sample_valid (sample_valid),
        .phase_tvalid (w_phase_tvalid),
        .phase_tready (phase_tready),
        .phase_tdata  (w_phase_tdata),
        .sweep_active (w_sweep_active),
        .step_last    (w_step_last),
        .sweep_done   (w_sweep_done)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w_q[$];
    int seg_cnt = 0;
    int step_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int done_w_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_sweep(input logic [31:0] s, input logic [31:0] st, input int n);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + st;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done_cnt, target);
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop;
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    // Scoreboard and pulse monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (phase_tvalid && phase_tready) begin
                hs_cnt++;
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("phase_tdata", phase_tdata, exp_q.pop_front());
            end
            if (step_last) begin
                step_cnt++;
                check_eq("step_len", seg_cnt, STEP_LEN);
                seg_cnt = 0;
            end else if (!sweep_active) begin
                seg_cnt = 0;
            end else if (!phase_tvalid && !sweep_done && sample_valid) begin
                seg_cnt++;
            end
            if (sweep_done) done_cnt++;

            if (w_phase_tvalid && phase_tready) begin
                check_eq("w_sb_nonempty", 32'(exp_w_q.size() != 0), 1);
                if (exp_w_q.size() != 0) check_eq("w_phase_tdata", w_phase_tdata, exp_w_q.pop_front());
            end
            if (w_sweep_done) done_w_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0, st0, d0, n;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tvalid", phase_tvalid, 0);
        check_eq("rst_tdata", phase_tdata, START);
        check_eq("rst_active", sweep_active, 0);
        check_eq("rst_step_last", step_last, 0);
        check_eq("rst_done", sweep_done, 0);
        check_eq("rst_w_tdata", w_phase_tdata, 32'hFFFFFFF0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full sweep(s), first LOAD held off for 10 cycles
        for (int s = 0; s < N_SWEEP; s++) push_sweep(START, STEP, NUM_STEPS);
`ifdef LFM_CONTINUOUS_EN
        exp_q.push_back(START);
`endif
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("bp_tvalid", phase_tvalid, 1);
            check_eq("bp_tdata", phase_tdata, START);
            @(posedge clk); #1;
        end
        check_eq("bp_no_hs", hs_cnt, 0);
        sample_valid = 1'b1;
        phase_tready = 1'b1;
        wait_done(N_SWEEP, 4000, "t1_done");
`ifdef LFM_CONTINUOUS_EN
        pulse_stop();
`endif
        repeat (5) @(negedge clk);
        check_eq("t1_steps", step_cnt, NUM_STEPS * N_SWEEP);
        check_eq("t1_dones", done_cnt, N_SWEEP);
        check_eq("t1_sb_left", exp_q.size(), 0);
        check_eq("t1_idle", sweep_active, 0);

        // Stop in LOAD under backpressure
        phase_tready = 1'b0;
        sample_valid = 1'b0;
        hs0 = hs_cnt; st0 = step_cnt; d0 = done_cnt;
        exp_q.push_back(START);
        pulse_start();
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("stl_tvalid", phase_tvalid, 1);
        end
        @(posedge clk); #1 phase_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("stl_idle", sweep_active, 0);
        check_eq("stl_tvalid_low", phase_tvalid, 0);
        sample_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("stl_one_hs", hs_cnt - hs0, 1);
        check_eq("stl_no_step", step_cnt, st0);
        check_eq("stl_no_done", done_cnt, d0);

        // Stop at sample 50 of DWELL
        hs0 = hs_cnt; st0 = step_cnt; d0 = done_cnt;
        push_sweep(START, STEP, NUM_STEPS);
        pulse_start();
        n = 0;
        while (seg_cnt < 50 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("std_reach50", 32'(seg_cnt >= 50), 1);
        pulse_stop();
        @(negedge clk);
        check_eq("std_idle", sweep_active, 0);
        repeat (3) @(negedge clk);
        check_eq("std_no_step", step_cnt, st0);
        check_eq("std_no_done", done_cnt, d0);
        check_eq("std_one_hs", hs_cnt - hs0, 1);
        exp_q.delete();

        // Reset mid-DWELL
        push_sweep(START, STEP, NUM_STEPS);
        pulse_start();
        repeat (30) @(negedge clk);
        check_eq("rd_in_dwell", {31'd0, sweep_active & ~phase_tvalid}, 1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check_eq("rd_tvalid", phase_tvalid, 0);
        check_eq("rd_tdata", phase_tdata, START);
        check_eq("rd_active", sweep_active, 0);
        check_eq("rd_step_last", step_last, 0);
        check_eq("rd_done", sweep_done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        hs0 = hs_cnt; st0 = step_cnt; d0 = done_cnt;
        repeat (20) @(negedge clk);
        check_eq("rd_needs_start", sweep_active, 0);
        check_eq("rd_no_hs", hs_cnt - hs0, 0);
        check_eq("rd_no_pulse", (step_cnt - st0) + (done_cnt - d0), 0);

        // Phase increment wrap on the second instance
        exp_w_q.push_back(32'hFFFFFFF0);
        exp_w_q.push_back(32'h00000010);
`ifdef LFM_CONTINUOUS_EN
        exp_w_q.push_back(32'hFFFFFFF0);
`endif
        @(posedge clk); #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        n = 0;
        while (done_w_cnt < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("w_done", done_w_cnt, 1);
`ifdef LFM_CONTINUOUS_EN
        pulse_stop();
`endif
        repeat (5) @(negedge clk);
        check_eq("w_sb_left", exp_w_q.size(), 0);
        check_eq("w_idle", w_sweep_active, 0);
        check_eq("w_dut0_idle", sweep_active, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lfm_sweep_ctrl.md
LFM_SWEEP_CTRL -- requirements
Module: lfm_sweep_ctrl

Interface
REQ-001 SHALL have parameter STEP_LEN, default 100, meaning DDS samples per frequency step (1..65535).
REQ-002 SHALL have parameter START_INC, default 32'h28F5C29, meaning the first-step phase increment.
REQ-003 SHALL have parameter STEP_INC, default 32'h28F5C29, meaning the increment added per step.
REQ-004 SHALL have parameter NUM_STEPS, default 16, meaning steps per sweep (1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request sweep start.
REQ-008 SHALL have port stop, input, 1 bit: request sweep abort.
REQ-009 SHALL have port sample_valid, input, 1 bit: DDS output-sample strobe that paces dwell.
REQ-010 SHALL have port phase_tvalid, output, 1 bit: AXI-Stream valid toward the DDS phase input.
REQ-011 SHALL have port phase_tready, input, 1 bit: AXI-Stream ready from the DDS.
REQ-012 SHALL have port phase_tdata, output, 32 bits: phase increment.
REQ-013 SHALL have port sweep_active, output, 1 bit: high in LOAD, DWELL or DONE.
REQ-014 SHALL have port step_last, output, 1 bit: one-cycle pulse on the final sample of each step.
REQ-015 SHALL have port sweep_done, output, 1 bit: one-cycle pulse at sweep end.

Function
REQ-016 SHALL implement states IDLE, LOAD, DWELL, DONE; all outputs registered.
REQ-017 In IDLE, a sampled start SHALL load phase_tdata=START_INC and step_idx=0, and move to LOAD; phase_tvalid SHALL go high on the next cycle.
REQ-018 In LOAD, phase_tvalid SHALL be 1 and phase_tdata SHALL be stable until phase_tvalid&phase_tready; on handshake, sample_cnt SHALL clear and the FSM SHALL enter DWELL with phase_tvalid=0 the next cycle.
REQ-019 sample_valid SHALL be ignored outside DWELL.
REQ-020 In DWELL, each sample_valid SHALL increment the 16-bit sample_cnt; sample_valid with sample_cnt==STEP_LEN-1 SHALL pulse step_last for one cycle.
REQ-021 At that final sample, if step_idx<NUM_STEPS-1, the block SHALL set phase_tdata to phase_tdata+STEP_INC (mod 2^32, wrap allowed) and step_idx+1, and go to LOAD; otherwise it SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle with sweep_done=1, then exit as defined in REQ-030/031.
REQ-023 start SHALL be ignored in any state other than IDLE.
REQ-024 stop SHALL have priority over start; in DWELL or DONE, stop SHALL force IDLE next cycle without pulsing step_last or sweep_done.
REQ-025 stop asserted in LOAD SHALL be latched and applied only after the pending handshake completes; phase_tvalid SHALL never drop without a handshake.
REQ-026 With STEP_LEN=1, every DWELL sample_valid SHALL end the step.

Reset
REQ-027 While reset=1, the block SHALL hold state=IDLE, phase_tvalid=0, phase_tdata=START_INC, sample_cnt=0, step_idx=0, step_last=0, sweep_done=0, sweep_active=0, and stop latch=0.
REQ-028 Reset asserted mid-sweep SHALL abort immediately and asynchronously, with no further pulses.
REQ-029 After reset deasserts, the block SHALL require a new start.

Configuration
REQ-030 With macro LFM_CONTINUOUS_EN defined, DONE SHALL go to LOAD with phase_tdata=START_INC and step_idx=0, repeating until stop or reset; sweep_done SHALL still pulse each sweep.
REQ-031 Without LFM_CONTINUOUS_EN, DONE SHALL go to IDLE.

Verification
REQ-032 Single sweep check: defaults, start pulse, phase_tready=1, sample_valid=1 continuously -> phase increments 0x28F5C29, 0x51EB852, ... 16 values; step_last every 100 samples; sweep_done once after 1600 samples.
REQ-033 Backpressure check: phase_tready=0 for 10 cycles in LOAD -> phase_tvalid held 1 and phase_tdata stable; sample_valid pulses ignored; DWELL entered only after handshake.
REQ-034 Wrap check: START_INC=32'hFFFFFFF0, STEP_INC=32'h20, NUM_STEPS=2 -> second increment equals 32'h00000010.
REQ-035 Stop check: stop asserted in LOAD with tready=0, tready raised after 5 cycles -> one handshake then IDLE; stop asserted at sample 50 of DWELL -> IDLE next cycle, no step_last or sweep_done.
REQ-036 Reset check: reset asserted mid-DWELL -> outputs at reset values immediately; with LFM_CONTINUOUS_EN defined, run 2 sweeps -> two sweep_done pulses and the 17th increment equals START_INC.
